pipelined_cpu: RTL and testbench
================================

// Module: pipelined_cpu
// PURPOSE
//  5-stage in-order MIPS-subset CPU core (F, D, E, M, W) with external instruction and data ports.
//  Fetches the instruction on i_datain for PC i_addr and decodes it in D.
//  Loads and stores go through the d_* port in M; results retire to a 32x32 register file in W.
//  Top-level processing core; instruction and data memories live outside.
// PARAMETERS
//  RESET_PC   32'h0   PC value loaded on reset
// PORTS
//  clock      in   1   single system clock; all state updates on rising edge
//  reset      in   1   synchronous, active-high reset
//  i_datain   in   32  instruction word for address i_addr (combinational fetch)
//  d_datain   in   32  load data for address d_addr (combinational read in M)
//  d_dataout  out  32  store data (rt value of instruction in M)
//  d_addr     out  32  data address = ALU result of instruction in M
//  i_addr     out  32  current fetch PC
//  d_we       out  1   store strobe: 1 while a sw occupies M
// BEHAVIOUR
//  - Reset (sync, active-high):
//    - PC <= RESET_PC; all pipeline registers <= bubble (NOP); gr[0..31] <= 0.
//    - Outputs then read i_addr=RESET_PC, d_addr=0, d_dataout=0, d_we=0.
//    - Reset mid-operation discards all in-flight instructions.
//  - gr[0] reads 0 always; writes to it are ignored.
//  - Register file is write-first: a W-stage write is visible to the D read in the same cycle.
//  - Decode map:
//    - R-type (op 000000) funct: sll 00, srl 02, sra 03, sllv 04, srlv 06, srav 07, jr 08,
//      add 20, addu 21, sub 22, subu 23, and 24, or 25, xor 26, nor 27, slt 2A.
//    - I/J-type op: j 02, jal 03, beq 04, bne 05, addi 08, addiu 09, andi 0C, ori 0D, lw 23, sw 2B.
//    - Any other opcode or funct executes as NOP; 32'h0 is NOP (sll $0).
//  - ALU (32-bit, wrap-around):
//    - add/addu/addi/addiu wrap with no overflow trap; sub/subu wrap likewise.
//    - slt is a signed compare giving 0 or 1.
//    - sll/srl/sra shift rt by shamt; sllv/srlv/srav shift rt by rs[4:0]; sra/srav are arithmetic.
//    - Immediates: addi/addiu/lw/sw sign-extend; andi/ori zero-extend.
//  - Destination register: R-type -> rd; I-type -> rt; jal -> 31, writing PC_of_jal+4.
//  - Control flow, resolved in D:
//    - beq/bne target = PC_D+4 + (sext(imm)<<2).
//    - j/jal target = {PC_D+4[31:28], imm26, 2'b00}.
//    - jr target = rs.
//    - When taken (or for any jump), the instruction fetched in the same cycle is squashed to a bubble.
//    - There is no delay slot; the next fetch is the target. Not-taken branches continue at PC+4.
//  - Forwarding:
//    - E operands take data from M (ALU result) or W (result); M has priority, never from $0.
//    - D branch/jr operands forward from M ALU result.
//  - Stalls (PC and F/D held, bubble inserted in E):
//    - 1 cycle when E holds lw whose rt is a source of the D instruction.
//    - 1 cycle when a D branch/jr depends on an ALU instruction in E.
//    - 2 cycles when it depends on a lw in E.
//    - Simultaneous stall and taken branch: the stall wins.
//  - Writeback result = lw ? d_datain (registered at end of M) : ALU/link value.
//  - Latency: an instruction fetched at cycle t writes gr at the end of cycle t+4.
//  - PC+4 wraps modulo 2^32.
//  - Debug names for the bench: gr[0:31], pcF, InstrF, SrcAE, SrcBE, ALUOutM, ResultW.
// STRUCTURE
//  - Package cpu_pkg:
//    - opcode/funct localparams.
//    - ALU-op enum.
//    - NOP constant.
//  - One sub-module, cpu_alu (A, B, shamt, aluop -> result).
//  - Register file, hazard unit and pipeline registers stay inline.
// TESTING
//  - Load then independent use:
//    - Reset, then lw gr1,0(gr0) with d_datain=1 presented while the lw is in M.
//    - Then lw gr2 with d_datain=2.
//    - Required: gr1=1, gr2=2.
//    - Then add gr7,gr1,gr2 -> gr7=3; sub gr7,gr1,gr2 -> gr7=FFFFFFFF.
//  - Forwarding:
//    - addi gr7,gr1,-16 followed immediately by addu gr8,gr7,gr7.
//    - Required: gr8=FFFFFFE2 with no stall.
//    - lw then a dependent add stalls exactly 1 cycle with correct sum.
//  - Branches:
//    - With gr1=1, gr2=2: beq gr1,gr2,4 is not taken (PC+4).
//    - bne gr1,gr2,4 at PC=0x38 sets the next i_addr=0x4C, and the following fetched word never writes back.
//  - Jumps:
//    - jal 0x20 at PC=0x54 -> i_addr=0x80, gr31=0x58.
//    - j 0x33 -> i_addr=0xCC.
//    - jr gr31 -> i_addr=gr31.
//  - Logic/shifts with gr3=3, gr5=5, gr6=FFFFFFFE:
//    - and=1, or=7, nor=FFFFFFF8, xor=6, andi 9=1, ori 9=B.
//    - sra gr6,1=FFFFFFFF; srl 2,1=1; sllv gr1<<gr2=4; slt(1,2)=1.
//  - Stores and reset:
//    - sw gr5,0x114(gr0) -> d_we=1, d_addr=0x114, d_dataout=5 during M.
//    - Reset asserted mid-stream -> i_addr=0, d_we=0 next cycle, all gr=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings, ALU operation set and decoded control bundle for pipelined_cpu.
package cpu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLLV, ALU_SRLV, ALU_SRAV
  } aluop_e;

  typedef struct packed {
    logic              regwrite;
    logic              memtoreg;
    logic              memwrite;
    logic              alusrc;
    logic              link;
    aluop_e            aluop;
    logic [REG_AW-1:0] dst;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{regwrite: 1'b0, memtoreg: 1'b0, memwrite: 1'b0,
                                 alusrc: 1'b0, link: 1'b0, aluop: ALU_ADD, dst: 5'd0};

  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0000;

endpackage

// File: rtl/cpu_alu.sv
// 32-bit wrap-around ALU: arithmetic, logic, signed compare and shifts.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0]   i_a,
  input  logic [XLEN-1:0]   i_b,
  input  logic [REG_AW-1:0] i_shamt,
  input  aluop_e            i_aluop,
  output logic [XLEN-1:0]   o_result_c
);

  always_comb begin
    o_result_c = '0;
    case (i_aluop)
      ALU_ADD:  o_result_c = i_a + i_b;
      ALU_SUB:  o_result_c = i_a - i_b;
      ALU_AND:  o_result_c = i_a & i_b;
      ALU_OR:   o_result_c = i_a | i_b;
      ALU_XOR:  o_result_c = i_a ^ i_b;
      ALU_NOR:  o_result_c = ~(i_a | i_b);
      ALU_SLT:  o_result_c = {31'd0, ($signed(i_a) < $signed(i_b))};
      ALU_SLL:  o_result_c = i_b << i_shamt;
      ALU_SRL:  o_result_c = i_b >> i_shamt;
      ALU_SRA:  o_result_c = $unsigned($signed(i_b) >>> i_shamt);
      ALU_SLLV: o_result_c = i_b << i_a[4:0];
      ALU_SRLV: o_result_c = i_b >> i_a[4:0];
      ALU_SRAV: o_result_c = $unsigned($signed(i_b) >>> i_a[4:0]);
      default:  o_result_c = '0;
    endcase
  end

endmodule

// File: rtl/pipelined_cpu.sv
// Five-stage in-order MIPS-subset core; branches resolve in D, memories are external.
module pipelined_cpu
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] i_datain,
  input  logic [31:0] d_datain,
  output logic [31:0] d_dataout,
  output logic [31:0] d_addr,
  output logic [31:0] i_addr,
  output logic        d_we
);

  logic [XLEN-1:0] gr [0:31];
  logic [XLEN-1:0] pcF, InstrF;

  logic [XLEN-1:0] r_instr_d, r_pc_d;
  logic [5:0]      w_op, w_funct;
  logic [4:0]      w_rs, w_rt, w_rd, w_shamt;
  logic [15:0]     w_imm16;
  ctrl_t           w_ctrl_d;
  logic            w_use_rs, w_use_rt, w_is_beq, w_is_bne, w_is_j, w_is_jr, w_zext;
  logic [XLEN-1:0] w_imm_d, w_rs_val_d, w_rt_val_d, w_br_a, w_br_b;
  logic [XLEN-1:0] w_pc_plus4_d, w_target_d;
  logic            w_taken, w_hit_e, w_hit_m_ld, w_stall;

  ctrl_t           r_ctrl_e;
  logic [XLEN-1:0] r_rs_val_e, r_rt_val_e, r_imm_e, r_link_e;
  logic [4:0]      r_rs_e, r_rt_e, r_shamt_e;
  logic [XLEN-1:0] SrcAE, SrcBE, w_rt_fwd_e, w_alu_e, w_result_e;
  logic            w_fwd_a_m, w_fwd_a_w, w_fwd_b_m, w_fwd_b_w;

  logic            r_regwrite_m, r_memtoreg_m, r_memwrite_m;
  logic [4:0]      r_dst_m;
  logic [XLEN-1:0] ALUOutM, r_wdata_m;

  logic            r_regwrite_w, r_memtoreg_w;
  logic [4:0]      r_dst_w;
  logic [XLEN-1:0] r_aluout_w, r_rdata_w, ResultW;

  assign InstrF    = i_datain;
  assign i_addr    = pcF;
  assign d_addr    = ALUOutM;
  assign d_dataout = r_wdata_m;
  assign d_we      = r_memwrite_m;

  assign w_op    = r_instr_d[31:26];
  assign w_rs    = r_instr_d[25:21];
  assign w_rt    = r_instr_d[20:16];
  assign w_rd    = r_instr_d[15:11];
  assign w_shamt = r_instr_d[10:6];
  assign w_funct = r_instr_d[5:0];
  assign w_imm16 = r_instr_d[15:0];

  // Decode; anything unrecognised stays a NOP
  always_comb begin
    w_ctrl_d = CTRL_NOP;
    w_use_rs = 1'b0;
    w_use_rt = 1'b0;
    w_is_beq = 1'b0;
    w_is_bne = 1'b0;
    w_is_j   = 1'b0;
    w_is_jr  = 1'b0;
    w_zext   = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        w_ctrl_d.dst = w_rd;
        w_use_rs     = 1'b1;
        w_use_rt     = 1'b1;
        w_ctrl_d.regwrite = 1'b1;
        case (w_funct)
          FN_SLL:  begin w_ctrl_d.aluop = ALU_SLL; w_use_rs = 1'b0; end
          FN_SRL:  begin w_ctrl_d.aluop = ALU_SRL; w_use_rs = 1'b0; end
          FN_SRA:  begin w_ctrl_d.aluop = ALU_SRA; w_use_rs = 1'b0; end
          FN_SLLV: w_ctrl_d.aluop = ALU_SLLV;
          FN_SRLV: w_ctrl_d.aluop = ALU_SRLV;
          FN_SRAV: w_ctrl_d.aluop = ALU_SRAV;
          FN_ADD, FN_ADDU: w_ctrl_d.aluop = ALU_ADD;
          FN_SUB, FN_SUBU: w_ctrl_d.aluop = ALU_SUB;
          FN_AND:  w_ctrl_d.aluop = ALU_AND;
          FN_OR:   w_ctrl_d.aluop = ALU_OR;
          FN_XOR:  w_ctrl_d.aluop = ALU_XOR;
          FN_NOR:  w_ctrl_d.aluop = ALU_NOR;
          FN_SLT:  w_ctrl_d.aluop = ALU_SLT;
          FN_JR: begin
            w_ctrl_d = CTRL_NOP;
            w_is_jr  = 1'b1;
            w_use_rt = 1'b0;
          end
          default: begin
            w_ctrl_d = CTRL_NOP;
            w_use_rs = 1'b0;
            w_use_rt = 1'b0;
          end
        endcase
      end
      OP_J:   w_is_j = 1'b1;
      OP_JAL: begin
        w_is_j            = 1'b1;
        w_ctrl_d.regwrite = 1'b1;
        w_ctrl_d.link     = 1'b1;
        w_ctrl_d.dst      = 5'd31;
      end
      OP_BEQ, OP_BNE: begin
        w_is_beq = (w_op == OP_BEQ);
        w_is_bne = (w_op == OP_BNE);
        w_use_rs = 1'b1;
        w_use_rt = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_LW: begin
        w_ctrl_d.regwrite = 1'b1;
        w_ctrl_d.alusrc   = 1'b1;
        w_ctrl_d.memtoreg = (w_op == OP_LW);
        w_ctrl_d.dst      = w_rt;
        w_use_rs          = 1'b1;
        w_zext            = (w_op == OP_ANDI) || (w_op == OP_ORI);
        w_ctrl_d.aluop    = (w_op == OP_ANDI) ? ALU_AND :
                            (w_op == OP_ORI)  ? ALU_OR  : ALU_ADD;
      end
      OP_SW: begin
        w_ctrl_d.memwrite = 1'b1;
        w_ctrl_d.alusrc   = 1'b1;
        w_use_rs          = 1'b1;
        w_use_rt          = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_imm_d = w_zext ? {16'd0, w_imm16} : {{16{w_imm16[15]}}, w_imm16};

  // Register read is write-first against the W stage
  assign w_rs_val_d = (w_rs == 5'd0) ? '0 :
                      (r_regwrite_w && r_dst_w == w_rs) ? ResultW : gr[w_rs];
  assign w_rt_val_d = (w_rt == 5'd0) ? '0 :
                      (r_regwrite_w && r_dst_w == w_rt) ? ResultW : gr[w_rt];

  assign w_br_a = (r_regwrite_m && !r_memtoreg_m && r_dst_m != 5'd0 && r_dst_m == w_rs)
                  ? ALUOutM : w_rs_val_d;
  assign w_br_b = (r_regwrite_m && !r_memtoreg_m && r_dst_m != 5'd0 && r_dst_m == w_rt)
                  ? ALUOutM : w_rt_val_d;

  assign w_pc_plus4_d = r_pc_d + 32'd4;

  always_comb begin
    w_target_d = w_pc_plus4_d + {w_imm_d[29:0], 2'b00};
    if (w_is_j)
      w_target_d = {w_pc_plus4_d[31:28], r_instr_d[25:0], 2'b00};
    else if (w_is_jr)
      w_target_d = w_br_a;
  end

  assign w_taken = w_is_j || w_is_jr ||
                   (w_is_beq && (w_br_a == w_br_b)) ||
                   (w_is_bne && (w_br_a != w_br_b));

  // Hazards: load-use from E, and branch operands still in flight in E or as a load in M
  assign w_hit_e = r_ctrl_e.regwrite && r_ctrl_e.dst != 5'd0 &&
                   ((w_use_rs && w_rs == r_ctrl_e.dst) || (w_use_rt && w_rt == r_ctrl_e.dst));
  assign w_hit_m_ld = r_memtoreg_m && r_dst_m != 5'd0 &&
                      ((w_use_rs && w_rs == r_dst_m) || (w_use_rt && w_rt == r_dst_m));
  assign w_stall = (w_hit_e && r_ctrl_e.memtoreg) ||
                   ((w_is_beq || w_is_bne || w_is_jr) && (w_hit_e || w_hit_m_ld));

  always_ff @(posedge clock) begin
    if (reset)
      pcF <= RESET_PC;
    else if (!w_stall)
      pcF <= w_taken ? w_target_d : pcF + 32'd4;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_instr_d <= INSTR_NOP;
      r_pc_d    <= '0;
    end else if (!w_stall) begin
      r_instr_d <= w_taken ? INSTR_NOP : InstrF;
      r_pc_d    <= pcF;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || w_stall) begin
      r_ctrl_e   <= CTRL_NOP;
      r_rs_val_e <= '0;
      r_rt_val_e <= '0;
      r_imm_e    <= '0;
      r_link_e   <= '0;
      r_rs_e     <= '0;
      r_rt_e     <= '0;
      r_shamt_e  <= '0;
    end else begin
      r_ctrl_e   <= w_ctrl_d;
      r_rs_val_e <= w_rs_val_d;
      r_rt_val_e <= w_rt_val_d;
      r_imm_e    <= w_imm_d;
      r_link_e   <= w_pc_plus4_d;
      r_rs_e     <= w_rs;
      r_rt_e     <= w_rt;
      r_shamt_e  <= w_shamt;
    end
  end

  // E operand bypass: M beats W, $0 never forwarded
  assign w_fwd_a_m = r_regwrite_m && r_dst_m != 5'd0 && r_dst_m == r_rs_e;
  assign w_fwd_a_w = r_regwrite_w && r_dst_w != 5'd0 && r_dst_w == r_rs_e;
  assign w_fwd_b_m = r_regwrite_m && r_dst_m != 5'd0 && r_dst_m == r_rt_e;
  assign w_fwd_b_w = r_regwrite_w && r_dst_w != 5'd0 && r_dst_w == r_rt_e;

  assign SrcAE      = w_fwd_a_m ? ALUOutM : w_fwd_a_w ? ResultW : r_rs_val_e;
  assign w_rt_fwd_e = w_fwd_b_m ? ALUOutM : w_fwd_b_w ? ResultW : r_rt_val_e;
  assign SrcBE      = r_ctrl_e.alusrc ? r_imm_e : w_rt_fwd_e;

  cpu_alu u_alu (
    .i_a        (SrcAE),
    .i_b        (SrcBE),
    .i_shamt    (r_shamt_e),
    .i_aluop    (r_ctrl_e.aluop),
    .o_result_c (w_alu_e)
  );

  assign w_result_e = r_ctrl_e.link ? r_link_e : w_alu_e;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_regwrite_m <= 1'b0;
      r_memtoreg_m <= 1'b0;
      r_memwrite_m <= 1'b0;
      r_dst_m      <= '0;
      ALUOutM      <= '0;
      r_wdata_m    <= '0;
    end else begin
      r_regwrite_m <= r_ctrl_e.regwrite;
      r_memtoreg_m <= r_ctrl_e.memtoreg;
      r_memwrite_m <= r_ctrl_e.memwrite;
      r_dst_m      <= r_ctrl_e.dst;
      ALUOutM      <= w_result_e;
      r_wdata_m    <= w_rt_fwd_e;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_regwrite_w <= 1'b0;
      r_memtoreg_w <= 1'b0;
      r_dst_w      <= '0;
      r_aluout_w   <= '0;
      r_rdata_w    <= '0;
    end else begin
      r_regwrite_w <= r_regwrite_m;
      r_memtoreg_w <= r_memtoreg_m;
      r_dst_w      <= r_dst_m;
      r_aluout_w   <= ALUOutM;
      r_rdata_w    <= d_datain;
    end
  end

  assign ResultW = r_memtoreg_w ? r_rdata_w : r_aluout_w;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) gr[i] <= '0;
    end else if (r_regwrite_w && r_dst_w != 5'd0) begin
      gr[r_dst_w] <= ResultW;
    end
  end

endmodule

// File: tb/tb_pipelined_cpu.sv
// Directed program run against pipelined_cpu with cycle-exact checks of PC, stores and registers.
module tb_pipelined_cpu;

  logic        clock;
  logic        reset;
  logic [31:0] i_datain, d_datain, d_dataout, d_addr, i_addr;
  logic        d_we;

  logic [31:0] imem [0:255];
  logic [31:0] dmem [0:63];
  logic [31:0] exp_gr [0:31];
  int          n_cmp, n_bad, cyc;

  pipelined_cpu #(.RESET_PC(32'h0)) dut (
    .clock     (clock),
    .reset     (reset),
    .i_datain  (i_datain),
    .d_datain  (d_datain),
    .d_dataout (d_dataout),
    .d_addr    (d_addr),
    .i_addr    (i_addr),
    .d_we      (d_we)
  );

  assign i_datain = imem[i_addr[9:2]];
  assign d_datain = dmem[d_addr[7:2]];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] jtype(input logic [5:0] op, input logic [25:0] idx);
    return {op, idx};
  endfunction

  task automatic put(input logic [31:0] a, input logic [31:0] w);
    imem[a[9:2]] = w;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, expv);
    end
  endtask

  task automatic run_to(input int n);
    while (cyc < n) begin
      @(posedge clock);
      #1;
      cyc++;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    for (int i = 0; i < 256; i++) imem[i] = 32'h0;
    for (int i = 0; i < 64; i++)  dmem[i] = 32'h0;
    dmem[0] = 32'd1;
    dmem[1] = 32'd2;

    put(32'h000, itype(6'h23, 0, 1, 16'h0000));   // lw   gr1,0(gr0)
    put(32'h004, itype(6'h23, 0, 2, 16'h0004));   // lw   gr2,4(gr0)
    put(32'h010, rtype(1, 2, 7, 0, 6'h20));       // add  gr7,gr1,gr2
    put(32'h014, rtype(1, 2, 7, 0, 6'h22));       // sub  gr7,gr1,gr2
    put(32'h018, itype(6'h08, 1, 7, 16'hFFF0));   // addi gr7,gr1,-16
    put(32'h01C, rtype(7, 7, 8, 0, 6'h21));       // addu gr8,gr7,gr7
    put(32'h020, itype(6'h23, 0, 9, 16'h0004));   // lw   gr9,4(gr0)
    put(32'h024, rtype(9, 1, 10, 0, 6'h20));      // add  gr10,gr9,gr1
    put(32'h02C, itype(6'h04, 1, 2, 16'h0004));   // beq  gr1,gr2,4
    put(32'h038, itype(6'h05, 1, 2, 16'h0004));   // bne  gr1,gr2,4
    put(32'h03C, itype(6'h08, 0, 20, 16'h0077));  // squashed marker
    put(32'h040, itype(6'h08, 0, 20, 16'h0078));  // skipped marker
    put(32'h054, jtype(6'h03, 26'h20));           // jal  0x20
    put(32'h058, jtype(6'h02, 26'h40));           // j    0x40
    put(32'h05C, itype(6'h08, 0, 25, 16'h0001));  // squashed marker
    put(32'h080, jtype(6'h02, 26'h33));           // j    0x33
    put(32'h084, itype(6'h08, 0, 22, 16'h0001));  // squashed marker
    put(32'h0CC, rtype(31, 0, 0, 0, 6'h08));      // jr   gr31
    put(32'h0D0, itype(6'h08, 0, 23, 16'h0001));  // squashed marker
    put(32'h100, itype(6'h08, 0, 3, 16'h0003));
    put(32'h104, itype(6'h08, 0, 5, 16'h0005));
    put(32'h108, itype(6'h08, 0, 6, 16'hFFFE));
    put(32'h10C, rtype(3, 5, 11, 0, 6'h24));      // and
    put(32'h110, rtype(3, 5, 12, 0, 6'h25));      // or
    put(32'h114, rtype(3, 5, 13, 0, 6'h27));      // nor
    put(32'h118, rtype(3, 5, 14, 0, 6'h26));      // xor
    put(32'h11C, itype(6'h0C, 3, 15, 16'h0009));  // andi
    put(32'h120, itype(6'h0D, 3, 16, 16'h0009));  // ori
    put(32'h124, rtype(0, 6, 17, 1, 6'h03));      // sra  gr17,gr6,1
    put(32'h128, rtype(0, 2, 18, 1, 6'h02));      // srl  gr18,gr2,1
    put(32'h12C, rtype(2, 1, 19, 0, 6'h04));      // sllv gr19,gr1,gr2
    put(32'h130, rtype(1, 2, 24, 0, 6'h2A));      // slt  gr24,gr1,gr2
    put(32'h134, itype(6'h2B, 0, 5, 16'h0114));   // sw   gr5,0x114(gr0)
    put(32'h138, jtype(6'h02, 26'h4E));           // j    self
    put(32'h13C, itype(6'h08, 0, 26, 16'h0001));  // squashed marker

    for (int i = 0; i < 32; i++) exp_gr[i] = 32'h0;
    exp_gr[1]  = 32'h1;        exp_gr[2]  = 32'h2;        exp_gr[3]  = 32'h3;
    exp_gr[5]  = 32'h5;        exp_gr[6]  = 32'hFFFFFFFE; exp_gr[7]  = 32'hFFFFFFF1;
    exp_gr[8]  = 32'hFFFFFFE2; exp_gr[9]  = 32'h2;        exp_gr[10] = 32'h3;
    exp_gr[11] = 32'h1;        exp_gr[12] = 32'h7;        exp_gr[13] = 32'hFFFFFFF8;
    exp_gr[14] = 32'h6;        exp_gr[15] = 32'h1;        exp_gr[16] = 32'hB;
    exp_gr[17] = 32'hFFFFFFFF; exp_gr[18] = 32'h1;        exp_gr[19] = 32'h4;
    exp_gr[24] = 32'h1;        exp_gr[31] = 32'h58;

    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    cyc   = 0;

    check("rst_i_addr", i_addr, 32'h0);
    check("rst_d_addr", d_addr, 32'h0);
    check("rst_d_dataout", d_dataout, 32'h0);
    check("rst_d_we", {31'd0, d_we}, 32'h0);
    for (int i = 0; i < 32; i++) check($sformatf("rst_gr%0d", i), dut.gr[i], 32'h0);

    run_to(5);  check("lw_gr1", dut.gr[1], 32'h1);
    run_to(6);  check("lw_gr2", dut.gr[2], 32'h2);
    run_to(9);  check("add_gr7", dut.gr[7], 32'h3);
                check("fwd_srca_m", dut.SrcAE, 32'hFFFFFFF1);
    run_to(10); check("sub_gr7", dut.gr[7], 32'hFFFFFFFF);
                check("pc_c10", i_addr, 32'h28);
    run_to(11); check("addu_not_yet", dut.gr[8], 32'h0);
                check("lw_use_hold", i_addr, 32'h28);
    run_to(12); check("addu_gr8", dut.gr[8], 32'hFFFFFFE2);
                check("pc_after_stall", i_addr, 32'h2C);
    run_to(14); check("ldadd_not_yet", dut.gr[10], 32'h0);
                check("beq_not_taken", i_addr, 32'h34);
    run_to(15); check("ldadd_gr10", dut.gr[10], 32'h3);
    run_to(16); check("bne_in_d", i_addr, 32'h3C);
    run_to(17); check("bne_target", i_addr, 32'h4C);
    run_to(20); check("jal_in_d", i_addr, 32'h58);
    run_to(21); check("jal_target", i_addr, 32'h80);
    run_to(23); check("j_target", i_addr, 32'hCC);
    run_to(24); check("jal_link", dut.gr[31], 32'h58);
    run_to(25); check("jr_target", i_addr, 32'h58);
    run_to(27); check("j_0x40", i_addr, 32'h100);
    run_to(42); check("no_store_yet", {31'd0, d_we}, 32'h0);
    run_to(43); check("sw_we", {31'd0, d_we}, 32'h1);
                check("sw_addr", d_addr, 32'h114);
                check("sw_data", d_dataout, 32'h5);
    run_to(50);
    for (int i = 0; i < 32; i++) check($sformatf("final_gr%0d", i), dut.gr[i], exp_gr[i]);

    // Second pass: restart, then reset while the store sits in M
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    cyc   = 0;
    run_to(43); check("rerun_sw_we", {31'd0, d_we}, 32'h1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("midrst_i_addr", i_addr, 32'h0);
    check("midrst_d_we", {31'd0, d_we}, 32'h0);
    check("midrst_d_addr", d_addr, 32'h0);
    for (int i = 0; i < 32; i++) check($sformatf("midrst_gr%0d", i), dut.gr[i], 32'h0);
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
